// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for sync_fifo_status: level/pointer widths and the
// wrap-at-depth pointer increment that supports depths that are not powers of two.
package sync_fifo_pkg;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 3) ? 1 : $clog2(depth);
  endfunction

  // Explicit compare so depths that are not powers of two wrap correctly.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_storage.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module fifo_storage #(
  parameter int unsigned DEPTH      = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_status.sv
// Single-clock FIFO with occupancy, almost flags, flush and sticky error flags.
// Optional same-cycle pass-through when empty: define SYNC_FIFO_BYPASS_EN.
module sync_fifo_status
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 5,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush_i,
  input  logic [DATA_WIDTH-1:0]                 push_data_i,
  input  logic                                  push_valid_i,
  output logic                                  push_grant_o,
  input  logic                                  pop_grant_i,
  output logic [DATA_WIDTH-1:0]                 pop_data_o,
  output logic                                  pop_valid_o,
  output logic [level_width(FIFO_DEPTH)-1:0]    level_o,
  output logic                                  almost_full_o,
  output logic                                  almost_empty_o,
  output logic                                  overflow_o,
  output logic                                  underflow_o,
  input  logic                                  clr_err_i
);

  localparam int unsigned LVL_W = level_width(FIFO_DEPTH);
  localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);

  if (!(FIFO_DEPTH >= 2 && AF_LEVEL > 0 && AF_LEVEL <= FIFO_DEPTH && AE_LEVEL < FIFO_DEPTH)) begin : g_param_check
    $fatal(1, "sync_fifo_status: illegal FIFO_DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q,  level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  not_full, not_empty;
  logic                  bypass;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] rdata;

  assign not_full  = (level_q != LVL_W'(FIFO_DEPTH));
  assign not_empty = (level_q != '0);

`ifdef SYNC_FIFO_BYPASS_EN
  assign bypass = ~not_empty & push_valid_i & pop_grant_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word never touches storage, so it must not count as a push.
  assign push = push_valid_i & not_full & ~bypass;
  assign pop  = not_empty & pop_grant_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), FIFO_DEPTH));
      if (pop)  rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), FIFO_DEPTH));
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
    end
    overflow_d  = clr_err_i ? 1'b0 : (overflow_q  | (push_valid_i & ~not_full));
    underflow_d = clr_err_i ? 1'b0 : (underflow_q | (pop_grant_i & ~not_empty & ~bypass));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_storage #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (PTR_W)
  ) u_storage (
    .clk     (clk),
    .we_i    (push & ~flush_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign push_grant_o   = not_full;
  assign pop_valid_o    = not_empty | bypass;
  assign pop_data_o     = bypass ? push_data_i : rdata;
  assign level_o        = level_q;
  assign almost_full_o  = (level_q >= LVL_W'(AF_LEVEL));
  assign almost_empty_o = (level_q <= LVL_W'(AE_LEVEL));
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_status.sv
// Directed bench for sync_fifo_status at DEPTH=5, AF=4, AE=1; the bypass case
// follows SYNC_FIFO_BYPASS_EN.
module tb_sync_fifo_status;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [31:0] push_data_i;
  logic        push_valid_i;
  logic        push_grant_o;
  logic        pop_grant_i;
  logic [31:0] pop_data_o;
  logic        pop_valid_o;
  logic [2:0]  level_o;
  logic        almost_full_o;
  logic        almost_empty_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        clr_err_i;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  sync_fifo_status #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (5),
    .AF_LEVEL   (4),
    .AE_LEVEL   (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .push_data_i    (push_data_i),
    .push_valid_i   (push_valid_i),
    .push_grant_o   (push_grant_o),
    .pop_grant_i    (pop_grant_i),
    .pop_data_o     (pop_data_o),
    .pop_valid_o    (pop_valid_o),
    .level_o        (level_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
    .clr_err_i      (clr_err_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 0; push_data_i = '0; push_valid_i = 0;
    pop_grant_i = 0; clr_err_i = 0;
    #12;
    n_tests++;
    if ({push_grant_o, pop_valid_o, level_o, almost_full_o, almost_empty_o, overflow_o, underflow_o}
        !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got gnt=%b vld=%b lvl=%0d af=%b ae=%b ovf=%b unf=%b, want 1 0 0 0 1 0 0",
               push_grant_o, pop_valid_o, level_o, almost_full_o, almost_empty_o, overflow_o, underflow_o);
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({push_grant_o, pop_valid_o, level_o} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL idle_state: got gnt=%b vld=%b lvl=%0d, want 1 0 0", push_grant_o, pop_valid_o, level_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      push_valid_i = 1; push_data_i = 32'hA0 + i;
      #1;
      n_tests++;
      if (push_grant_o !== 1'b1) begin
        n_fail++; $display("FAIL fill_grant[%0d]: got %b want 1", i, push_grant_o);
      end
      tick();
      n_tests++;
      if ({level_o, almost_full_o, almost_empty_o} !== {3'(i + 1), (i + 1 >= 4), (i + 1 <= 1)}) begin
        n_fail++;
        $display("FAIL fill_level[%0d]: got lvl=%0d af=%b ae=%b want lvl=%0d af=%b ae=%b",
                 i, level_o, almost_full_o, almost_empty_o, i + 1, (i + 1 >= 4), (i + 1 <= 1));
      end
    end
    n_tests++;
    if (push_grant_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL full_grant: got gnt=%b ovf=%b want 0 0", push_grant_o, overflow_o);
    end
    push_data_i = 32'hEE;
    tick();
    push_valid_i = 0;
    #1;
    n_tests++;
    if ({overflow_o, level_o, pop_data_o} !== {1'b1, 3'd5, 32'hA0}) begin
      n_fail++;
      $display("FAIL overflow: got ovf=%b lvl=%0d head=%h want 1 5 a0", overflow_o, level_o, pop_data_o);
    end
  endtask

  task automatic test_drain();
    pop_grant_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (pop_valid_o !== 1'b1 || pop_data_o !== 32'hA0 + i) begin
        n_fail++;
        $display("FAIL drain[%0d]: got vld=%b data=%h want 1 %h", i, pop_valid_o, pop_data_o, 32'hA0 + i);
      end
      tick();
    end
    n_tests++;
    if ({pop_valid_o, level_o, almost_empty_o, underflow_o} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL drained: got vld=%b lvl=%0d ae=%b unf=%b want 0 0 1 0",
               pop_valid_o, level_o, almost_empty_o, underflow_o);
    end
    tick();
    pop_grant_i = 0;
    n_tests++;
    if (underflow_o !== 1'b1) begin
      n_fail++; $display("FAIL underflow: got %b want 1", underflow_o);
    end
    clr_err_i = 1;
    tick();
    clr_err_i = 0;
    n_tests++;
    if ({overflow_o, underflow_o} !== 2'b00) begin
      n_fail++; $display("FAIL clr_err: got ovf=%b unf=%b want 0 0", overflow_o, underflow_o);
    end
  endtask

  task automatic test_back_to_back();
    push_valid_i = 1;
    for (int i = 0; i < 2; i++) begin
      push_data_i = 32'hB0 + i;
      tick();
    end
    pop_grant_i = 1;
    for (int i = 0; i < 12; i++) begin
      push_data_i = 32'hB2 + i;
      #1;
      n_tests++;
      if (pop_data_o !== 32'hB0 + i) begin
        n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, pop_data_o, 32'hB0 + i);
      end
      tick();
      n_tests++;
      if (level_o !== 3'd2) begin
        n_fail++; $display("FAIL b2b_level[%0d]: got %0d want 2", i, level_o);
      end
    end
    push_valid_i = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (pop_data_o !== 32'hBC + i) begin
        n_fail++; $display("FAIL b2b_tail[%0d]: got %h want %h", i, pop_data_o, 32'hBC + i);
      end
      tick();
    end
    pop_grant_i = 0;
    n_tests++;
    if (level_o !== 3'd0 || underflow_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got lvl=%0d unf=%b want 0 0", level_o, underflow_o);
    end
  endtask

  task automatic test_flush();
    push_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      push_data_i = 32'hC0 + i;
      tick();
    end
    flush_i = 1; push_data_i = 32'h99;
    tick();
    flush_i = 0; push_valid_i = 0;
    n_tests++;
    if ({level_o, pop_valid_o, push_grant_o} !== {3'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL flush: got lvl=%0d vld=%b gnt=%b want 0 0 1", level_o, pop_valid_o, push_grant_o);
    end
    push_valid_i = 1; push_data_i = 32'h55;
    tick();
    push_valid_i = 0;
    n_tests++;
    if ({level_o, pop_valid_o, pop_data_o} !== {3'd1, 1'b1, 32'h55}) begin
      n_fail++;
      $display("FAIL post_flush: got lvl=%0d vld=%b data=%h want 1 1 55", level_o, pop_valid_o, pop_data_o);
    end
    pop_grant_i = 1;
    tick();
    pop_grant_i = 0;
    n_tests++;
    if (level_o !== 3'd0 || underflow_o !== 1'b0) begin
      n_fail++; $display("FAIL post_flush_pop: got lvl=%0d unf=%b want 0 0", level_o, underflow_o);
    end
  endtask

  task automatic test_bypass();
    push_valid_i = 1; pop_grant_i = 1; push_data_i = 32'h77;
    #1;
`ifdef SYNC_FIFO_BYPASS_EN
    n_tests++;
    if (pop_valid_o !== 1'b1 || pop_data_o !== 32'h77) begin
      n_fail++; $display("FAIL bypass_comb: got vld=%b data=%h want 1 77", pop_valid_o, pop_data_o);
    end
    tick();
    push_valid_i = 0; pop_grant_i = 0;
    n_tests++;
    if (level_o !== 3'd0 || underflow_o !== 1'b0) begin
      n_fail++; $display("FAIL bypass_state: got lvl=%0d unf=%b want 0 0", level_o, underflow_o);
    end
`else
    n_tests++;
    if (pop_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL nobypass_comb: got vld=%b want 0", pop_valid_o);
    end
    tick();
    push_valid_i = 0; pop_grant_i = 0;
    n_tests++;
    if ({level_o, pop_data_o, underflow_o} !== {3'd1, 32'h77, 1'b1}) begin
      n_fail++;
      $display("FAIL nobypass_state: got lvl=%0d data=%h unf=%b want 1 77 1", level_o, pop_data_o, underflow_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_status.md
Name: sync_fifo_status

Overview:
Single-clock parametrised FIFO with valid/grant handshakes on both sides, arbitrary (non-power-of-two) depth, occupancy output, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags. It is the general-purpose buffer between stimulus/producer blocks and consumers in the datapath, and replaces fixed-depth, power-of-two-only buffering.

Parameters:
DATA_WIDTH, 32, payload width in bits (exactly DATA_WIDTH bits, no extra bit)
FIFO_DEPTH, 5, number of entries; any integer >= 2
AF_LEVEL, FIFO_DEPTH-1, almost_full_o asserted when level >= AF_LEVEL
AE_LEVEL, 1, almost_empty_o asserted when level <= AE_LEVEL

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous clear of contents and pointers
push_data_i  in  DATA_WIDTH  write data
push_valid_i  in  1  producer offers data
push_grant_o  out  1  FIFO can accept (not full)
pop_grant_i  in  1  consumer accepts data
pop_data_o  out  DATA_WIDTH  head-of-FIFO data
pop_valid_o  out  1  FIFO has data (not empty)
level_o  out  $clog2(FIFO_DEPTH+1)  current occupancy
almost_full_o  out  1  level >= AF_LEVEL
almost_empty_o  out  1  level <= AE_LEVEL
overflow_o  out  1  sticky: push_valid_i seen while full
underflow_o  out  1  sticky: pop_grant_i seen while empty
clr_err_i  in  1  clears both sticky error flags

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, level=0 -> push_grant_o=1, pop_valid_o=0, level_o=0, almost_full_o=0 (AF_LEVEL>0), almost_empty_o=1, overflow_o=0, underflow_o=0. Storage contents not reset; pop_data_o don't-care while pop_valid_o=0.
- push = push_valid_i & push_grant_o; pop = pop_valid_o & pop_grant_i. Transfers occur on the rising edge where asserted.
- push_grant_o = (level != FIFO_DEPTH); pop_valid_o = (level != 0); both driven from registered level only (no combinational input->output path).
- pop_data_o = storage[rd_ptr], combinational read; first-word fall-through: data written at edge N is visible with pop_valid_o=1 after edge N (latency 1 cycle).
- Pointers: increment on transfer, wrap from FIFO_DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- level: +1 push only, -1 pop only, unchanged on simultaneous push&pop or neither. Simultaneous push&pop legal when full (pop frees slot only next cycle: grant=0 when full, so push blocked) and when empty (pop blocked, push proceeds).
- flush_i=1: at next edge pointers and level return to 0; any push/pop in same cycle discarded; error flags unaffected. flush has priority over push/pop.
- overflow_o set at edge where push_valid_i & !push_grant_o; underflow_o set where pop_grant_i & !pop_valid_o; both held until clr_err_i=1 (clear wins over set same cycle) or reset.
- almost flags combinational from registered level.
- Elaboration check: FIFO_DEPTH >= 2, 0 < AF_LEVEL <= FIFO_DEPTH, AE_LEVEL < FIFO_DEPTH; violation -> $fatal.

Optional Feature:
Macro SYNC_FIFO_BYPASS_EN. Defined: when level==0, push_valid_i=1 and pop_grant_i=1, data passes straight through: pop_valid_o=1, pop_data_o=push_data_i in the same cycle, nothing written, level stays 0; push_grant_o unchanged. Adds combinational path push_valid_i->pop_valid_o; underflow not flagged in that case. Undefined: no bypass, pure registered status as above, latency 1.

Decomposition:
- Package sync_fifo_pkg: function level width (clog2(depth+1)), pointer width (clog2(depth), min 1), pointer-increment-with-wrap function.
- One sub-module fifo_storage: DEPTH x DATA_WIDTH register array, one synchronous write port (we, waddr, wdata), one combinational read port (raddr, rdata). Control logic stays in top.

Test Plan:
- Reset then idle -> push_grant_o=1, pop_valid_o=0, level_o=0, almost_empty_o=1, errors 0.
- DEPTH=5: push 0xA0..0xA4 back-to-back, pop_grant_i=0 -> level_o 1..5, almost_full_o at level 4, push_grant_o=0 after 5th; 6th push_valid_i -> overflow_o=1, data unchanged.
- Drain with pop_grant_i=1 -> pop_data_o 0xA0,0xA1..0xA4 in order, one per cycle, pop_valid_o=0 after; extra pop_grant_i -> underflow_o=1; clr_err_i pulse -> both 0.
- Continuous push&pop for 12 cycles at level 2 -> level_o stays 2, pointers wrap past 4, output order matches input.
- Fill to 3, assert flush_i with push_valid_i=1 -> next cycle level_o=0, pop_valid_o=0; subsequent push 0x55 pops 0x55.
- SYNC_FIFO_BYPASS_EN defined, empty, push 0x77 with pop_grant_i=1 -> pop_data_o=0x77 same cycle, level_o stays 0.
